uart_tx_queue: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_queue_if.sv | 33 +++
 rtl/uart_tx_queue_sync_fifo.sv | 59 +++++
 rtl/uart_tx_queue.sv | 85 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
// The launch sequencer's state type lives here so checkers can decode the debug state output.
package uart_pkg;

  localparam int UART_DW   = 8;
  localparam int TXQ_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bundle between a byte producer / UART transmitter pair and the uart_tx_queue block.
// The slave modport is the queue's view; the master modport is the environment's view.
interface uart_tx_queue_if
  import uart_pkg::*;
#(
  parameter int DW = UART_DW,
  parameter int LW = $clog2(TXQ_DEPTH) + 1
);

  // Producer handshake: a byte transfers on every rising edge where i_valid && o_ready.
  // i_valid may be raised regardless of o_ready; offering while o_ready is low drops the byte
  // and sets the sticky o_overflow. Transmitter side: o_tx_start is a one-cycle strobe,
  // o_tx_data holds until the next strobe, i_tx_busy is the transmitter's serialising flag.
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_tx_start;
  logic [DW-1:0] o_tx_data;
  logic          i_tx_busy;
  logic [LW-1:0] o_level;
  logic          o_overflow;

  modport slave (
    input  i_valid, i_data, i_tx_busy,
    output o_ready, o_tx_start, o_tx_data, o_level, o_overflow
  );

  modport master (
    output i_valid, i_data, i_tx_busy,
    input  o_ready, o_tx_start, o_tx_data, o_level, o_overflow
  );

endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: o_dout always shows the head entry.
// Pointers wrap modulo DEPTH (power of two); push when full and pop when empty are ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DW    = UART_DW,
  parameter int DEPTH = TXQ_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      // Simultaneous push and pop leaves the level unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch sequencer feeding a UART transmitter's start/data/busy interface.
// Holds bytes in sync_fifo and launches one byte per transmitter frame.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DW    = UART_DW,
  parameter int DEPTH = TXQ_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            i_reset,
  uart_tx_queue_if.slave  bus,
  output txq_state_t      o_state
);

  txq_state_t    r_state;
  txq_state_t    w_next;
  logic          r_tx_start;
  logic [DW-1:0] r_tx_data;
  logic          r_overflow;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_dout;
  logic [LW-1:0] w_level;
  logic          w_full;
  logic          w_empty;

  // Ready comes from the registered level only, so a pop in the same cycle cannot free a full queue.
  assign w_ready = !w_full;
  assign w_push  = bus.i_valid && w_ready;
  assign w_pop   = (r_state == LAUNCH);

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.i_data),
    .o_dout  (w_dout),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!w_empty && !bus.i_tx_busy) w_next = LAUNCH;
      LAUNCH:    w_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.i_tx_busy) w_next = WAIT_DONE;
      WAIT_DONE: if (!bus.i_tx_busy) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Strobe and data load on the edge into LAUNCH so both are valid together during LAUNCH;
  // the FIFO head is then popped at the end of LAUNCH.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_start <= (w_next == LAUNCH);
      if (w_next == LAUNCH) r_tx_data <= w_dout;
      if (bus.i_valid && !w_ready) r_overflow <= 1'b1;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_tx_start = r_tx_start;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_level    = w_level;
  assign bus.o_overflow = r_overflow;
  assign o_state        = r_state;

endmodule
